// File: rtl/tick_timer.sv
// Programmable countdown timer: a synchronised, edge-detected tick_in decrements a loadable
// counter, with one-shot or periodic reload, an expiry pulse and a sticky flag.
module tick_timer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic             flag
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   busy_q, busy_d;
  logic                   expired_q, expired_d;
  logic                   flag_q, flag_d;
  logic                   tick;

  assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], tick_in};
    hist_d    = sync_q[SYNC_STAGES-1];
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d = load_value;
          if (load_value != '0) begin
            state_d = StRun;
          end else begin
            expired_d = 1'b1;
          end
        end
      end
      StRun: begin
        // stop beats start, and start beats a coincident tick.
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          count_d = load_value;
        end else if (tick) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            expired_d = 1'b1;
            if (periodic && (load_value != '0)) begin
              count_d = load_value;
            end else begin
              count_d = '0;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun);
    flag_d = expired_d | (flag_q & ~clear_flag);
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      hist_q    <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      flag_q    <= flag_d;
    end
  end

  assign count   = count_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign flag    = flag_q;

endmodule
